// File: rtl/fetch_controller_pkg.sv
// Shared fetch-side constants: instruction width, default reset PC,
// controller state encodings and the PC step.
package fetch_controller_pkg;

    localparam int FC_INST_WIDTH = 32;
    localparam int FC_RESET_PC   = 0;
    localparam int FC_PC_INC     = 4;

    typedef enum logic [1:0] {
        FC_IDLE = 2'd0,
        FC_RUN  = 2'd1,
        FC_HALT = 2'd2
    } fc_state_e;

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready output stage between fetch and decode.
// Flush beats load; an accepted word empties the slot unless refilled.
module fetch_out_reg
    import fetch_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int INST_WIDTH = FC_INST_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_flush,
    input  logic                  i_ready,
    input  logic [INST_WIDTH-1:0] i_inst,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic                  o_valid,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [ADDR_WIDTH-1:0] o_pc
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_inst  <= '0;
            o_pc    <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_inst  <= i_inst;
            o_pc    <= i_pc;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Front-end fetch sequencer: owns the PC, drives the combinational imem,
// registers fetched words toward decode, handles redirects and halt.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int INST_WIDTH = FC_INST_WIDTH,
    parameter int RESET_PC   = FC_RESET_PC
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic [INST_WIDTH-1:0] i_imem_inst,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic                  o_valid,
    input  logic                  i_ready,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_halted,
    output logic                  o_misalign
);

    fc_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  halted_d, misalign_d;
    logic                  load, flush, slot_free;

    assign o_imem_addr = pc_q;
    assign slot_free   = !o_valid || i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= FC_IDLE;
            pc_q       <= ADDR_WIDTH'(RESET_PC);
            o_halted   <= 1'b0;
            o_misalign <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            o_halted   <= halted_d;
            o_misalign <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        halted_d   = o_halted;
        misalign_d = 1'b0;
        load       = 1'b0;
        flush      = 1'b0;
        if (i_redirect) begin
            // Redirect always discards the pending word, good target or not.
            flush = 1'b1;
            if (i_redirect_pc[1:0] == 2'b00) begin
                pc_d     = i_redirect_pc;
                halted_d = 1'b0;
                if (state_q != FC_IDLE) state_d = FC_RUN;
            end else begin
                misalign_d = 1'b1;
                halted_d   = 1'b1;
                state_d    = FC_HALT;
            end
        end else begin
            unique case (state_q)
                FC_IDLE: if (i_start) state_d = FC_RUN;
                FC_RUN: begin
                    if (slot_free) begin
                        if (i_imem_inst != '0) begin
                            load = 1'b1;
                            pc_d = pc_q + ADDR_WIDTH'(FC_PC_INC);
                        end else begin
                            halted_d = 1'b1;
                            state_d  = FC_HALT;
                        end
                    end
                end
                FC_HALT: ;
                default: state_d = FC_IDLE;
            endcase
        end
    end

    fetch_out_reg #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .INST_WIDTH(INST_WIDTH)
    ) u_out (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_load (load),
        .i_flush(flush),
        .i_ready(i_ready),
        .i_inst (i_imem_inst),
        .i_pc   (pc_q),
        .o_valid(o_valid),
        .o_inst (o_inst),
        .o_pc   (o_pc)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed + randomized bench for fetch_controller against a cycle-level
// behavioural model of the fetch rules, with a word-array instruction memory.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, ready, redirect;
    logic [9:0]  redirect_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] inst;
    logic [9:0]  pc;
    logic        valid, halted, misalign;

    logic [31:0] mem [0:255];
    assign imem_inst = mem[imem_addr[9:2]];

    always #5 clk = ~clk;

    fetch_controller dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .o_imem_addr  (imem_addr),
        .i_imem_inst  (imem_inst),
        .o_inst       (inst),
        .o_pc         (pc),
        .o_valid      (valid),
        .i_ready      (ready),
        .i_redirect   (redirect),
        .i_redirect_pc(redirect_pc),
        .o_halted     (halted),
        .o_misalign   (misalign)
    );

    int total = 0;
    int bad   = 0;

    // Model: mode 0 = waiting for start, 1 = fetching, 2 = stopped
    int          m_mode;
    int unsigned m_fpc;
    int unsigned m_opc;
    logic [31:0] m_inst;
    bit          m_valid, m_halt, m_mis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_fpc = 0; m_opc = 0; m_inst = 0;
        m_valid = 0; m_halt = 0; m_mis = 0;
    endtask

    task automatic check_model();
        chk("valid",    32'(valid),     32'(m_valid));
        chk("inst",     inst,           m_inst);
        chk("pc",       32'(pc),        m_opc);
        chk("halted",   32'(halted),    32'(m_halt));
        chk("misalign", 32'(misalign),  32'(m_mis));
        chk("addr",     32'(imem_addr), m_fpc);
    endtask

    // Advance one clock: derive next model state from the inputs as set now.
    task automatic tick();
        int          n_mode = m_mode;
        int unsigned n_fpc  = m_fpc, n_opc = m_opc;
        logic [31:0] n_inst = m_inst, w;
        bit          n_valid = m_valid, n_halt = m_halt, n_mis = 0;
        if (redirect) begin
            n_valid = 0;
            if (redirect_pc % 4 == 0) begin
                n_fpc = redirect_pc; n_halt = 0;
                if (m_mode != 0) n_mode = 1;
            end else begin
                n_mis = 1; n_halt = 1; n_mode = 2;
            end
        end else if (m_mode == 0) begin
            if (start) n_mode = 1;
        end else if (m_mode == 1) begin
            if (!m_valid || ready) begin
                w = mem[m_fpc / 4];
                if (w != 0) begin
                    n_valid = 1; n_inst = w; n_opc = m_fpc;
                    n_fpc = (m_fpc + 4) % 1024;
                end else begin
                    n_valid = 0; n_halt = 1; n_mode = 2;
                end
            end
        end else if (m_valid && ready) begin
            n_valid = 0;
        end
        @(posedge clk); #1;
        m_mode = n_mode; m_fpc = n_fpc; m_opc = n_opc; m_inst = n_inst;
        m_valid = n_valid; m_halt = n_halt; m_mis = n_mis;
        check_model();
    endtask

    task automatic redirect_to(input logic [9:0] target);
        redirect = 1'b1; redirect_pc = target;
        tick();
        redirect = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h00108113; mem[1] = 32'h00108193;
        mem[2] = 32'h00310233; mem[3] = 32'hfe218ae3; mem[4] = 32'h0;
        start = 0; ready = 1; redirect = 0; redirect_pc = 0;
        rst_n = 0;
        model_reset();
        #12;
        chk("rst_valid",  32'(valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_addr",   32'(imem_addr), 0);
        #4 rst_n = 1;
        @(posedge clk); #1;
        check_model();

        // Straight-line program up to the zero word
        start = 1; tick(); start = 0;
        tick(); chk("s1_pc0", 32'(pc), 32'h0); chk("s1_w0", inst, 32'h00108113);
        tick(); chk("s1_pc4", 32'(pc), 32'h4); chk("s1_w1", inst, 32'h00108193);
        tick(); chk("s1_pc8", 32'(pc), 32'h8); chk("s1_w2", inst, 32'h00310233);
        tick(); chk("s1_pcc", 32'(pc), 32'hc); chk("s1_w3", inst, 32'hfe218ae3);
        tick(); chk("s1_halt", 32'(halted), 1); chk("s1_addr", 32'(imem_addr), 32'h10);
        chk("s1_nvld", 32'(valid), 0);
        tick();

        // Restart from HALT, then stall with o_pc=4
        redirect_to(10'h0); chk("s4_unhalt", 32'(halted), 0);
        tick(); chk("s4_w0", inst, 32'h00108113);
        tick();
        ready = 0;
        repeat (3) begin
            tick(); chk("s2_hold", inst, 32'h00108193); chk("s2_addr", 32'(imem_addr), 32'h8);
        end
        ready = 1;
        tick(); chk("s2_next", inst, 32'h00310233); chk("s2_pc", 32'(pc), 32'h8);
        tick(); chk("s3_pcc", 32'(pc), 32'hc);

        // Redirect with a valid word pending
        redirect_to(10'h4); chk("s3_flush", 32'(valid), 0);
        tick(); chk("s3_pc", 32'(pc), 32'h4); chk("s3_w", inst, 32'h00108193);

        // Misaligned target
        redirect_to(10'h6);
        chk("s5_mis", 32'(misalign), 1); chk("s5_addr", 32'(imem_addr), 32'h8);
        tick(); chk("s5_mis_off", 32'(misalign), 0);
        tick();

        // Random image; first check the PC wrap at the top of memory
        for (int i = 0; i < 256; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? 32'h0 : ($urandom | 32'h1);
        mem[254] = 32'h11; mem[255] = 32'h22; mem[0] = 32'h33;
        redirect_to(10'h3F8);
        tick(); tick();
        chk("wrap_pc", 32'(pc), 32'h3FC); chk("wrap_addr", 32'(imem_addr), 32'h0);
        tick();

        for (int c = 0; c < 600; c++) begin
            ready    = ($urandom_range(0, 3) != 0);
            start    = ($urandom_range(0, 7) == 0);
            redirect = ($urandom_range(0, 15) == 0);
            redirect_pc = 10'($urandom) & (($urandom_range(0, 3) == 0) ? 10'h3FF : 10'h3FC);
            tick();
        end
        start = 0; redirect = 0; ready = 1;
        redirect_to(10'h3F8);
        tick();

        // Asynchronous reset between clock edges
        @(posedge clk); #3 rst_n = 0;
        #1;
        chk("arst_valid", 32'(valid), 0);
        chk("arst_inst",  inst, 0);
        chk("arst_pc",    32'(pc), 0);
        chk("arst_halt",  32'(halted), 0);
        chk("arst_mis",   32'(misalign), 0);
        chk("arst_addr",  32'(imem_addr), 0);
        model_reset();
        #3 rst_n = 1;
        repeat (3) tick();
        start = 1; tick(); start = 0;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
